// File: rtl/dmux4way_reg.sv
// dmux4way_reg: 1-to-4 demux with a combinational path, a registered valid-qualified path and saturating per-channel counters.
module dmux4way_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             valid_in,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] d_q,
  output logic             valid_q,
  output logic [3:0]       onehot_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [3:0]       w_dec;
  logic [3:0]       w_hit;
  logic [WIDTH-1:0] r_q   [4];
  logic [CNT_W-1:0] r_cnt [4];
  logic             r_valid;
  logic [3:0]       r_onehot;
  always_comb begin
    w_dec = 4'b0001 << sel;
    w_hit = valid_in ? w_dec : 4'b0000;
    a     = w_dec[0] ? in : '0;
    b     = w_dec[1] ? in : '0;
    c     = w_dec[2] ? in : '0;
    d     = w_dec[3] ? in : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_onehot <= 4'b0000;
    end else begin
      r_valid  <= valid_in;
      r_onehot <= w_hit;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    // Unselected or idle channels are driven to zero rather than holding data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q[i]   <= '0;
        r_cnt[i] <= '0;
      end else begin
        r_q[i]   <= w_hit[i] ? in : '0;
        r_cnt[i] <= clr_cnt ? '0 :
                    (w_hit[i] && r_cnt[i] != CNT_MAX) ? r_cnt[i] + 1'b1 : r_cnt[i];
      end
    end
  end
  assign a_q      = r_q[0];
  assign b_q      = r_q[1];
  assign c_q      = r_q[2];
  assign d_q      = r_q[3];
  assign valid_q  = r_valid;
  assign onehot_q = r_onehot;
  assign cnt_a    = r_cnt[0];
  assign cnt_b    = r_cnt[1];
  assign cnt_c    = r_cnt[2];
  assign cnt_d    = r_cnt[3];
endmodule

// File: tb/tb_dmux4way_reg.sv
// tb_dmux4way_reg: table-driven, directed and random checks of dmux4way_reg against a behavioural model.
module tb_dmux4way_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in = 4'h0;
  logic [1:0] sel = 2'd0;
  logic       valid_in = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [3:0] a, b, c, d, a_q, b_q, c_q, d_q, onehot_q;
  logic       valid_q;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic       a1, b1, c1, d1, a1_q, b1_q, c1_q, d1_q, valid1_q;
  logic [3:0] onehot1_q;
  logic [1:0] cnt1_a, cnt1_b, cnt1_c, cnt1_d;
  int checks = 0;
  int errors = 0;
  int         m_cnt  [4];
  int         m1_cnt [4];
  logic [3:0] m_q    [4];
  logic       m_v;
  logic [3:0] m_oh;

  dmux4way_reg #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .valid_in(valid_in), .clr_cnt(clr_cnt),
    .a(a), .b(b), .c(c), .d(d), .a_q(a_q), .b_q(b_q), .c_q(c_q), .d_q(d_q),
    .valid_q(valid_q), .onehot_q(onehot_q),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d));

  dmux4way_reg #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in[0]), .sel(sel), .valid_in(valid_in), .clr_cnt(clr_cnt),
    .a(a1), .b(b1), .c(c1), .d(d1), .a_q(a1_q), .b_q(b1_q), .c_q(c1_q), .d_q(d1_q),
    .valid_q(valid1_q), .onehot_q(onehot1_q),
    .cnt_a(cnt1_a), .cnt_b(cnt1_b), .cnt_c(cnt1_c), .cnt_d(cnt1_d));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  in;
    logic [15:0] exp_abcd;
    logic [3:0]  exp1_abcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m1_cnt[i] = 0;
      m_q[i] = 4'h0;
    end
    m_v = 1'b0;
    m_oh = 4'h0;
  endtask

  task automatic model_edge();
    m_v = valid_in;
    m_oh = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_q[i] = (valid_in && int'(sel) == i) ? in : 4'h0;
      if (valid_in && int'(sel) == i) m_oh[i] = 1'b1;
      if (clr_cnt) begin
        m_cnt[i] = 0;
        m1_cnt[i] = 0;
      end else if (valid_in && int'(sel) == i) begin
        m_cnt[i] = (m_cnt[i] < 7) ? m_cnt[i] + 1 : 7;
        m1_cnt[i] = (m1_cnt[i] < 3) ? m1_cnt[i] + 1 : 3;
      end
    end
  endtask

  task automatic check_all();
    chk("a", a, sel == 2'd0 ? in : 4'h0);
    chk("b", b, sel == 2'd1 ? in : 4'h0);
    chk("c", c, sel == 2'd2 ? in : 4'h0);
    chk("d", d, sel == 2'd3 ? in : 4'h0);
    chk("a_q", a_q, m_q[0]);
    chk("b_q", b_q, m_q[1]);
    chk("c_q", c_q, m_q[2]);
    chk("d_q", d_q, m_q[3]);
    chk("valid_q", valid_q, m_v);
    chk("onehot_q", onehot_q, m_oh);
    chk("cnt_a", cnt_a, m_cnt[0]);
    chk("cnt_b", cnt_b, m_cnt[1]);
    chk("cnt_c", cnt_c, m_cnt[2]);
    chk("cnt_d", cnt_d, m_cnt[3]);
    chk("w1_reg", {a1_q, b1_q, c1_q, d1_q},
        {m_q[0][0], m_q[1][0], m_q[2][0], m_q[3][0]});
    chk("w1_valid", valid1_q, m_v);
    chk("w1_onehot", onehot1_q, m_oh);
    chk("w1_cnt", {cnt1_a, cnt1_b, cnt1_c, cnt1_d},
        {2'(m1_cnt[0]), 2'(m1_cnt[1]), 2'(m1_cnt[2]), 2'(m1_cnt[3])});
  endtask

  task automatic cyc(input logic v, input logic [1:0] s, input logic [3:0] i, input logic cl);
    valid_in = v;
    sel = s;
    in = i;
    clr_cnt = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    vec_t vt[8];
    vt[0] = '{2'd0, 4'h1, 16'h1000, 4'b1000};
    vt[1] = '{2'd1, 4'h1, 16'h0100, 4'b0100};
    vt[2] = '{2'd2, 4'h1, 16'h0010, 4'b0010};
    vt[3] = '{2'd3, 4'h1, 16'h0001, 4'b0001};
    vt[4] = '{2'd0, 4'hA, 16'hA000, 4'b0000};
    vt[5] = '{2'd1, 4'hF, 16'h0F00, 4'b0100};
    vt[6] = '{2'd2, 4'h6, 16'h0060, 4'b0000};
    vt[7] = '{2'd3, 4'h0, 16'h0000, 4'b0000};
    model_reset();
    for (int k = 0; k < 8; k++) begin
      sel = vt[k].sel;
      in = vt[k].in;
      #1;
      chk("comb_tbl", {a, b, c, d}, vt[k].exp_abcd);
      chk("comb_tbl_w1", {a1, b1, c1, d1}, vt[k].exp1_abcd);
    end
    chk("rst_state", {a_q, b_q, c_q, d_q, onehot_q, 3'(valid_q), cnt_a, cnt_b, cnt_c, cnt_d}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 2'd2, 4'h1, 1'b0);
    chk("first_c_q", c_q, 4'h1);
    chk("first_onehot", onehot_q, 4'b0100);
    chk("first_cnt_c", cnt_c, 3'd1);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    cyc(1'b1, 2'd0, 4'h3, 1'b0);
    cyc(1'b1, 2'd1, 4'h0, 1'b0);
    cyc(1'b1, 2'd1, 4'h7, 1'b0);
    cyc(1'b1, 2'd3, 4'h9, 1'b0);
    cyc(1'b0, 2'd2, 4'hF, 1'b0);
    chk("burst_cnts", {cnt_a, cnt_b, cnt_c, cnt_d}, {3'd1, 3'd2, 3'd0, 3'd1});
    chk("idle_regs", {a_q, b_q, c_q, d_q, onehot_q, 3'(valid_q)}, '0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'd3, 4'h1, 1'b0);
    chk("sat_w1_cnt_d", cnt1_d, 2'd3);
    cyc(1'b1, 2'd1, 4'h9, 1'b1);
    chk("clr_pri_cnts", {cnt_a, cnt_b, cnt_c, cnt_d}, '0);
    chk("clr_pri_b_q", b_q, 4'h9);
    cyc(1'b1, 2'd0, 4'h5, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst", {a_q, 3'(valid_q), onehot_q, cnt_a, cnt_b, cnt_c, cnt_d}, '0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 400; k++)
      cyc(($urandom % 4) != 0, 2'($urandom), 4'($urandom), ($urandom % 40) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
